// File: rtl/id_stage_pipe.sv
// Instruction-decode stage for the 16-bit MIPS pipeline.
// Holds the register file and provides a WB->ID write bypass and load-use
// hazard detection. It also holds the registered ID/EX boundary, which
// supports hold, flush and bubble insertion, and a saturating stall-cycle
// counter.
module id_stage_pipe #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned INST_W  = 16,
  parameter int unsigned RA_W    = 3,
  parameter bit          R0_ZERO = 1'b1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [INST_W-1:0] inst,
  input  logic [RA_W-1:0]   read1_addr,
  input  logic [RA_W-1:0]   read2_addr,
  input  logic              use1,
  input  logic              use2,
  input  logic              wb_wr_en,
  input  logic [RA_W-1:0]   wb_address_input,
  input  logic [DATA_W-1:0] wb_data_input,
  input  logic              ex_mem_read,
  input  logic [RA_W-1:0]   ex_dest_addr,
  input  logic              hold,
  input  logic              flush,
  input  logic [RA_W-1:0]   test_reg_selector,
  output logic              stall,
  output logic              valid_out,
  output logic [INST_W-1:0] inst_out,
  output logic [DATA_W-1:0] read1,
  output logic [DATA_W-1:0] read2,
  output logic [RA_W-1:0]   rs_out,
  output logic [RA_W-1:0]   rt_out,
  output logic [DATA_W-1:0] test_selected_reg,
  output logic [CNT_W-1:0]  stall_count
);

  localparam int unsigned NREG = 2 ** RA_W;

  // Register file read with bypass. Register 0 is hardwired to zero when
  // R0_ZERO is set. A write in the same cycle wins over the stored value.
  function automatic logic [DATA_W-1:0] f_rf_read(
    input logic [RA_W-1:0]   addr,
    input logic              we,
    input logic [RA_W-1:0]   waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] v;
    if (R0_ZERO && (addr == {RA_W{1'b0}})) begin
      v = {DATA_W{1'b0}};
    end else if (we && (waddr == addr)) begin
      v = wdata;
    end else begin
      v = stored;
    end
    return v;
  endfunction

  logic [DATA_W-1:0] r_rf [0:NREG-1];
  logic              r_valid;
  logic [INST_W-1:0] r_inst;
  logic [DATA_W-1:0] r_read1;
  logic [DATA_W-1:0] r_read2;
  logic [RA_W-1:0]   r_rs;
  logic [RA_W-1:0]   r_rt;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_rf_we;
  logic              w_dest_live;
  logic              w_src_match;
  logic              w_stall;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  // Write strobe, load-use hazard and bypassed operand reads.
  always_comb begin
    w_rf_we     = 1'b0;
    w_dest_live = 1'b0;
    w_src_match = 1'b0;
    w_stall     = 1'b0;
    w_rd1       = {DATA_W{1'b0}};
    w_rd2       = {DATA_W{1'b0}};

    w_rf_we     = wb_wr_en & ~(R0_ZERO & (wb_address_input == {RA_W{1'b0}}));
    w_dest_live = (ex_dest_addr != {RA_W{1'b0}}) | ~R0_ZERO;
    w_src_match = (use1 & (ex_dest_addr == read1_addr)) |
                  (use2 & (ex_dest_addr == read2_addr));
    // A flush kills the instruction anyway, so it never needs to stall.
    if (flush) begin
      w_stall = 1'b0;
    end else begin
      w_stall = in_valid & ex_mem_read & w_dest_live & w_src_match;
    end

    w_rd1 = f_rf_read(read1_addr, wb_wr_en, wb_address_input, wb_data_input,
                      r_rf[read1_addr]);
    w_rd2 = f_rf_read(read2_addr, wb_wr_en, wb_address_input, wb_data_input,
                      r_rf[read2_addr]);
  end

  // Register file storage: cleared on reset, written from writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_rf[i] <= {DATA_W{1'b0}};
      end
    end else if (w_rf_we) begin
      r_rf[wb_address_input] <= wb_data_input;
    end
  end

  // ID/EX boundary. Priority is flush, then hold, then stall bubble, then capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_inst  <= {INST_W{1'b0}};
      r_read1 <= {DATA_W{1'b0}};
      r_read2 <= {DATA_W{1'b0}};
      r_rs    <= {RA_W{1'b0}};
      r_rt    <= {RA_W{1'b0}};
    end else if (flush || (!hold && w_stall)) begin
      r_valid <= 1'b0;
      r_inst  <= {INST_W{1'b0}};
      r_read1 <= {DATA_W{1'b0}};
      r_read2 <= {DATA_W{1'b0}};
      r_rs    <= {RA_W{1'b0}};
      r_rt    <= {RA_W{1'b0}};
    end else if (!hold) begin
      r_valid <= in_valid;
      r_inst  <= inst;
      r_read1 <= w_rd1;
      r_read2 <= w_rd2;
      r_rs    <= read1_addr;
      r_rt    <= read2_addr;
    end
  end

  // Saturating count of cycles actually spent inserting hazard bubbles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_stall && !hold && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall             = w_stall;
  assign valid_out         = r_valid;
  assign inst_out          = r_inst;
  assign read1             = r_read1;
  assign read2             = r_read2;
  assign rs_out            = r_rs;
  assign rt_out            = r_rt;
  assign test_selected_reg = r_rf[test_reg_selector];
  assign stall_count       = r_cnt;

endmodule
